sprite_index_gen: RTL and testbench
===================================

# sprite_index_gen

Pixel-index generator that feeds the 3-bit palette decoder in the VGA graphics path. It owns the 640x480 raster counters and produces hsync/vsync/active. It also overlays one SPR_W x SPR_H sprite, fetched from an external synchronous index ROM, on a constant background index. Its color_idx output drives the palette decoder's 3-bit color input directly; sync and active are delayed to stay aligned with color_idx.

## Interface
- H_ACTIVE, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48 (line total 800)
- V_ACTIVE, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33 (frame total 525)
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in lines
- BG_IDX, 3'd1, index output outside the sprite
- TRANSP_IDX, 3'd0, sprite ROM value treated as transparent (shows BG_IDX)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- pix_en  in  1  pixel-rate enable; all raster and pipeline state advances only when high
- sprite_x  in  10  requested sprite left column
- sprite_y  in  10  requested sprite top line
- pos_valid  in  1  one-clk strobe capturing sprite_x/sprite_y as pending position
- rom_addr  out  log2(SPR_W*SPR_H)  sprite ROM address, registered
- rom_data  in  3  ROM index, valid one clk after rom_addr changes
- color_idx  out  3  palette index to decoder; 0 when not active
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- active  out  1  high during visible pixels, aligned with color_idx
- frame_start  out  1  one-clk pulse when the pipeline presents pixel (0,0)

## Operation
- Stage 0 has two counters. hc counts 0..799 and vc counts 0..524. On pix_en, hc increments. At hc=799, hc wraps to 0 and vc increments. At vc=524 with hc=799, vc wraps to 0.
- Raw sync: hsync low for hc in [656,751]; vsync low for vc in [490,491]; active when hc<640 and vc<480.
- Sprite position: pos_valid loads a pending register. The live position register (sx,sy) copies pending only at end of frame: pix_en, hc=799 and vc=524. This prevents tearing.
  - If pos_valid and the frame-end update happen in the same clk, the new inputs go straight to live and pending.
  - Multiple strobes within one frame: the last one wins.
- Hit test uses 11-bit arithmetic so sx+SPR_W never wraps: hit = hc>=sx, hc<sx+SPR_W, vc>=sy, vc<sy+SPR_H, and active.
- Stage 1 (on pix_en) registers hit, active, hsync, vsync, and the frame_start condition. When hit, it registers rom_addr = (vc-sy)*SPR_W + (hc-sx); otherwise rom_addr holds its value.
- Stage 2 (on pix_en) registers all outputs:
  - color_idx = 0 if not active.
  - color_idx = BG_IDX if active and not hit.
  - color_idx = BG_IDX if hit and rom_data = TRANSP_IDX.
  - color_idx = rom_data otherwise.
- frame_start is high for exactly the one clk following the stage-2 pix_en that presents hc=0, vc=0.

## Timing
- Latency: outputs reflect counter state after 2 pix_en ticks. hsync, vsync, active and color_idx stay mutually aligned.
- rom_addr is stable between pix_en ticks. The ROM is read every clk with 1-clk latency, so pix_en may be high every clk (1:1 pixel clock) or every Nth clk.
- With pix_en low, all state holds and outputs are constant. frame_start is the only exception: it drops after one clk.
- Reset, asynchronous on rst_n low, at any point including mid-line:
  - hc = vc = 0
  - sx = sy = 0 and pending = 0
  - rom_addr = 0, color_idx = 0
  - hsync = 1, vsync = 1, active = 0, frame_start = 0
- After release, the first valid pixel (0,0) appears at the second pix_en. frame_start pulses then.

## Test plan
- Reset then free-run with pix_en every clk:
  - hsync low for 96 of every 800 ticks.
  - vsync low for exactly 2 lines per 525.
  - active high 640x480 per frame.
  - frame_start once per 420000 ticks.
- Sprite at sx=100, sy=50, with ROM returning (addr mod 8), TRANSP_IDX=0:
  - Pixel (100,50) gives BG_IDX (ROM value 0 is transparent).
  - Pixel (101,50) gives 1.
  - Pixel (131,81) gives rom_addr 1023 and color 7.
  - Pixel (132,50) gives BG_IDX.
- Update mid-frame: pos_valid with (200,200) at line 100 leaves the current frame drawing at the old position. The new position is used from the next frame_start. A strobe coincident with the frame-end tick also takes effect at the next frame.
- Clipping with sx=620, sy=470: the sprite is drawn only for hc 620..639 and vc 470..479; blanking outputs color_idx=0. With sx=1000, no hit anywhere and no wrap.
- pix_en every 2nd clk: timing and counts match the 1:1 case scaled by 2, and outputs hold between enables.
- Assert rst_n low mid-line inside the sprite: outputs take reset values immediately, without waiting for clk. After release the raster restarts at (0,0) with the sprite at (0,0).

Source files
------------

// File: rtl/sprite_index_gen.sv
//==============================================================================
// Module : sprite_index_gen
// Desc   : VGA raster counters, sync generation and single-sprite palette-index
//          overlay fetched from an external synchronous index ROM.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module sprite_index_gen #(
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter int         SPR_W      = 32,
  parameter int         SPR_H      = 32,
  parameter logic [2:0] BG_IDX     = 3'd1,
  parameter logic [2:0] TRANSP_IDX = 3'd0,
  localparam int        ADDR_W     = $clog2(SPR_W * SPR_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              pos_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [2:0]        color_idx,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              frame_start
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = ADDR_W - COL_W;

  localparam logic [9:0] c_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]        r_hc, r_vc;
  logic [9:0]        r_pend_x, r_pend_y, r_sx, r_sy;
  logic              r_hit_s1, r_act_s1, r_hs_s1, r_vs_s1, r_fs_s1;
  logic              w_line_end, w_frame_end;
  logic              w_act_raw, w_hs_raw, w_vs_raw, w_hit;
  logic [10:0]       w_hc_x, w_vc_x, w_sx_x, w_sy_x;
  logic [COL_W-1:0]  w_dx;
  logic [ROW_W-1:0]  w_dy;
  logic [2:0]        w_color;

  assign w_line_end  = (r_hc == c_H_LAST);
  assign w_frame_end = pix_en && w_line_end && (r_vc == c_V_LAST);

  // Stage 0: raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (pix_en) begin
      if (w_line_end) begin
        r_hc <= '0;
        r_vc <= (r_vc == c_V_LAST) ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Live position only changes on the frame-end tick so a frame is never torn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_x <= '0;
      r_pend_y <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
    end else begin
      if (pos_valid) begin
        r_pend_x <= sprite_x;
        r_pend_y <= sprite_y;
      end
      if (w_frame_end) begin
        r_sx <= pos_valid ? sprite_x : r_pend_x;
        r_sy <= pos_valid ? sprite_y : r_pend_y;
      end
    end
  end

  assign w_act_raw = (r_hc < c_H_ACT) && (r_vc < c_V_ACT);
  assign w_hs_raw  = !((r_hc >= c_HS_START) && (r_hc < c_HS_END));
  assign w_vs_raw  = !((r_vc >= c_VS_START) && (r_vc < c_VS_END));

  // 11-bit compare so sx+SPR_W near 1023 cannot wrap into a false hit
  assign w_hc_x = {1'b0, r_hc};
  assign w_vc_x = {1'b0, r_vc};
  assign w_sx_x = {1'b0, r_sx};
  assign w_sy_x = {1'b0, r_sy};
  assign w_hit  = w_act_raw
               && (w_hc_x >= w_sx_x) && (w_hc_x < w_sx_x + 11'(SPR_W))
               && (w_vc_x >= w_sy_x) && (w_vc_x < w_sy_x + 11'(SPR_H));

  // Offsets are below SPR_W/SPR_H on a hit, so the low bits give exact values
  assign w_dx = r_hc[COL_W-1:0] - r_sx[COL_W-1:0];
  assign w_dy = r_vc[ROW_W-1:0] - r_sy[ROW_W-1:0];

  // Stage 1: registered hit/sync/active and ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_s1 <= 1'b0;
      r_act_s1 <= 1'b0;
      r_hs_s1  <= 1'b1;
      r_vs_s1  <= 1'b1;
      r_fs_s1  <= 1'b0;
      rom_addr <= '0;
    end else if (pix_en) begin
      r_hit_s1 <= w_hit;
      r_act_s1 <= w_act_raw;
      r_hs_s1  <= w_hs_raw;
      r_vs_s1  <= w_vs_raw;
      r_fs_s1  <= (r_hc == 10'd0) && (r_vc == 10'd0);
      if (w_hit) begin
        rom_addr <= {w_dy, w_dx};
      end
    end
  end

  always_comb begin
    w_color = 3'd0;
    if (r_act_s1) begin
      if (r_hit_s1 && (rom_data != TRANSP_IDX)) begin
        w_color = rom_data;
      end else begin
        w_color = BG_IDX;
      end
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_idx   <= 3'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && r_fs_s1;
      if (pix_en) begin
        color_idx <= w_color;
        hsync     <= r_hs_s1;
        vsync     <= r_vs_s1;
        active    <= r_act_s1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_index_gen.sv
//==============================================================================
// Module : tb_sprite_index_gen
// Desc   : Self-checking bench for sprite_index_gen on a reduced raster.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_sprite_index_gen;

  localparam int H_ACT = 64, H_FP = 8, H_SY = 16, H_BP = 8;
  localparam int V_ACT = 40, V_FP = 3, V_SY = 2, V_BP = 5;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int SPR_W = 16, SPR_H = 8;
  localparam int AW    = $clog2(SPR_W * SPR_H);
  localparam logic [2:0] BG = 3'd1, TR = 3'd0;
  localparam logic [AW+6:0] c_RST = {{AW{1'b0}}, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic          clk, rst_n, pix_en, pos_valid;
  logic [9:0]    sprite_x, sprite_y;
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_data, color_idx;
  logic          hsync, vsync, active, frame_start;
  logic [2:0]    rom_mem [0:(1<<AW)-1];

  sprite_index_gen #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .SPR_W(SPR_W), .SPR_H(SPR_H), .BG_IDX(BG), .TRANSP_IDX(TR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .pos_valid(pos_valid),
    .rom_addr(rom_addr), .rom_data(rom_data), .color_idx(color_idx),
    .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start)
  );

  // ROM data settles within the clock after the address changes
  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [AW+6:0] obs_w = {rom_addr, color_idx, hsync, vsync, active, frame_start};

  typedef struct {
    int h; int v; logic hit; logic [AW-1:0] addr;
    logic [2:0] color; logic hs; logic vs; logic act; logic fs;
  } exp_t;

  int            n, m_sx, m_sy, m_px, m_py;
  int            n_cmp, n_err;
  exp_t          exp_s1, exp_out;
  logic [AW-1:0] exp_addr;
  logic          exp_fs;

  function automatic exp_t reset_exp();
    exp_t e;
    e.h = -1; e.v = -1; e.hit = 1'b0; e.addr = '0;
    e.color = 3'd0; e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  // What the picture should be at raster position idx, from the display rules
  function automatic exp_t model(int idx);
    exp_t e;
    logic [2:0] r;
    e.h   = idx % H_TOT;
    e.v   = idx / H_TOT;
    e.act = (e.h < H_ACT) && (e.v < V_ACT);
    e.hs  = !((e.h >= H_ACT + H_FP) && (e.h < H_ACT + H_FP + H_SY));
    e.vs  = !((e.v >= V_ACT + V_FP) && (e.v < V_ACT + V_FP + V_SY));
    e.fs  = (idx == 0);
    e.hit = e.act && (e.h >= m_sx) && (e.h < m_sx + SPR_W)
                  && (e.v >= m_sy) && (e.v < m_sy + SPR_H);
    e.addr = e.hit ? AW'((e.v - m_sy) * SPR_W + (e.h - m_sx)) : '0;
    r = rom_mem[e.addr];
    if (!e.act)                   e.color = 3'd0;
    else if (!e.hit || r == TR)   e.color = BG;
    else                          e.color = r;
    return e;
  endfunction

  function automatic logic [AW+6:0] exp_vec();
    return {exp_addr, exp_out.color, exp_out.hs, exp_out.vs, exp_out.act, exp_fs};
  endfunction

  task automatic model_reset();
    n = 0; m_sx = 0; m_sy = 0; m_px = 0; m_py = 0;
    exp_s1 = reset_exp(); exp_out = reset_exp(); exp_addr = '0; exp_fs = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; pix_en = 1'b0; pos_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the expected pipeline advances on pixel ticks
  task automatic step(input logic en, input logic pv, input int x, input int y);
    exp_t e;
    int idx;
    pix_en = en; pos_valid = pv; sprite_x = 10'(x); sprite_y = 10'(y);
    idx = n % FRAME;
    e = model(idx);
    @(posedge clk);
    if (en) begin
      exp_out = exp_s1;
      exp_s1  = e;
      if (e.hit) exp_addr = e.addr;
      if (idx == FRAME - 1) begin
        m_sx = pv ? x : m_px;
        m_sy = pv ? y : m_py;
      end
      n++;
    end
    if (pv) begin m_px = x; m_py = y; end
    exp_fs = en && exp_out.fs;
    #1;
  endtask

  task automatic rom_fill(input int mode);
    for (int i = 0; i < (1 << AW); i++)
      rom_mem[i] = (mode == 0) ? 3'(i % 8) : (mode == 1) ? 3'($urandom_range(0, 7)) : 3'd7;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_w !== c_RST) begin
      n_err++; $display("FAIL reset_async got %h want %h", obs_w, c_RST);
    end
    rom_fill(0);
    apply_reset();
    n_cmp++;
    if (obs_w !== c_RST) begin
      n_err++; $display("FAIL reset_release got %h want %h", obs_w, c_RST);
    end
    for (int k = 1; k <= 3; k++) begin
      step(k != 3, 1'b0, 0, 0);
      n_cmp++;
      if (obs_w !== exp_vec()) begin
        n_err++; $display("FAIL reset_first k=%0d got %h want %h", k, obs_w, exp_vec());
      end
      n_cmp++;
      if (frame_start !== (k == 2)) begin
        n_err++; $display("FAIL reset_fs k=%0d got %b want %b", k, frame_start, k == 2);
      end
    end
  endtask

  task automatic test_free_run();
    int hs_lo, vs_lo, act_hi, fs_cnt;
    hs_lo = 0; vs_lo = 0; act_hi = 0; fs_cnt = 0;
    rom_fill(0);
    apply_reset();
    for (int k = 1; k <= 2 * FRAME + 2; k++) begin
      step(1'b1, k == 1, 10, 5);
      n_cmp++;
      if (obs_w !== exp_vec()) begin
        n_err++; $display("FAIL free_run n=%0d got %h want %h", n, obs_w, exp_vec());
      end
      if (n >= 2 && n <= FRAME + 1) begin
        hs_lo += !hsync; vs_lo += !vsync; act_hi += active; fs_cnt += frame_start;
      end
      if (n >= FRAME + 2 && n <= 2 * FRAME + 1) begin
        if ((exp_out.h == 10 || exp_out.h == 11 || exp_out.h == 26) && exp_out.v == 5) begin
          n_cmp++;
          if (color_idx !== BG) begin
            n_err++; $display("FAIL spot_bg (%0d,5) got %0d want %0d", exp_out.h, color_idx, BG);
          end
        end
        if (exp_out.h == 25 && exp_out.v == 12) begin
          n_cmp++;
          if (rom_addr !== AW'(127) || color_idx !== 3'd7) begin
            n_err++; $display("FAIL spot_last got addr %0d color %0d want 127 7", rom_addr, color_idx);
          end
        end
      end
    end
    n_cmp += 4;
    if (hs_lo !== H_SY * V_TOT) begin n_err++; $display("FAIL hsync_count got %0d want %0d", hs_lo, H_SY * V_TOT); end
    if (vs_lo !== V_SY * H_TOT) begin n_err++; $display("FAIL vsync_count got %0d want %0d", vs_lo, V_SY * H_TOT); end
    if (act_hi !== H_ACT * V_ACT) begin n_err++; $display("FAIL active_count got %0d want %0d", act_hi, H_ACT * V_ACT); end
    if (fs_cnt !== 1) begin n_err++; $display("FAIL fs_count got %0d want 1", fs_cnt); end
  endtask

  task automatic test_mid_update();
    int ax, ay, bx, by, cx, cy, dx, dy;
    logic pv;
    int x, y;
    ax = $urandom_range(0, H_ACT - 1); ay = $urandom_range(0, V_ACT - 1);
    bx = $urandom_range(0, H_ACT - 1); by = $urandom_range(0, V_ACT - 1);
    cx = $urandom_range(0, H_ACT - 2); cy = $urandom_range(0, V_ACT - 1);
    dx = $urandom_range(0, 1023);      dy = $urandom_range(0, 1023);
    rom_fill(1);
    apply_reset();
    for (int k = 1; k <= 3 * FRAME + 2; k++) begin
      pv = 1'b0; x = 0; y = 0;
      if (k == 1)                                 begin pv = 1'b1; x = ax; y = ay; end
      else if (n == FRAME + 5 * H_TOT)            begin pv = 1'b1; x = dx; y = dy; end
      else if (n == FRAME + 20 * H_TOT)           begin pv = 1'b1; x = bx; y = by; end
      else if (n == 2 * FRAME - 1)                begin pv = 1'b1; x = cx; y = cy; end
      step(1'b1, pv, x, y);
      n_cmp++;
      if (obs_w !== exp_vec()) begin
        n_err++; $display("FAIL mid_update n=%0d got %h want %h", n, obs_w, exp_vec());
      end
      if (n >= 2 * FRAME + 2 && exp_out.h == cx && exp_out.v == cy) begin
        n_cmp++;
        if (rom_addr !== AW'(1)) begin
          n_err++; $display("FAIL coincident_pos got addr %0d want 1", rom_addr);
        end
      end
    end
  endtask

  task automatic test_clip();
    int hits2, hits3;
    hits2 = 0; hits3 = 0;
    rom_fill(2);
    apply_reset();
    for (int k = 1; k <= 3 * FRAME + 2; k++) begin
      if (k == 1) step(1'b1, 1'b1, H_ACT - 8, V_ACT - 4);
      else if (k == FRAME + 10) step(1'b1, 1'b1, 1000, 10);
      else step(1'b1, 1'b0, 0, 0);
      n_cmp++;
      if (obs_w !== exp_vec()) begin
        n_err++; $display("FAIL clip n=%0d got %h want %h", n, obs_w, exp_vec());
      end
      if (n >= FRAME + 2 && n <= 2 * FRAME + 1) hits2 += (color_idx == 3'd7);
      if (n >= 2 * FRAME + 2 && n <= 3 * FRAME + 1) hits3 += (color_idx == 3'd7);
    end
    n_cmp += 2;
    if (hits2 !== 32) begin n_err++; $display("FAIL clip_count got %0d want 32", hits2); end
    if (hits3 !== 0) begin n_err++; $display("FAIL offscreen_count got %0d want 0", hits3); end
  endtask

  task automatic test_half_rate();
    int hs_clk, fs_clk;
    hs_clk = 0; fs_clk = 0;
    rom_fill(1);
    apply_reset();
    for (int k = 1; k <= 2 * (FRAME + 2); k++) begin
      step(k % 2 == 0, k == 1, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
      n_cmp++;
      if (obs_w !== exp_vec()) begin
        n_err++; $display("FAIL half_rate k=%0d got %h want %h", k, obs_w, exp_vec());
      end
      if (n >= 2 && n <= FRAME + 1) begin
        hs_clk += !hsync; fs_clk += frame_start;
      end
    end
    n_cmp += 2;
    if (hs_clk !== 2 * H_SY * V_TOT) begin n_err++; $display("FAIL half_hsync got %0d want %0d", hs_clk, 2 * H_SY * V_TOT); end
    if (fs_clk !== 1) begin n_err++; $display("FAIL half_fs got %0d want 1", fs_clk); end
  endtask

  task automatic test_reset_mid_sprite();
    logic found;
    found = 1'b0;
    rom_fill(1);
    apply_reset();
    for (int k = 1; k <= 3 * FRAME && !found; k++) begin
      step(1'b1, k == 1, 10, 5);
      if (n >= FRAME + 2 && exp_out.h == 12 && exp_out.v == 6) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL mid_sprite_reach got 0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_w !== c_RST) begin
      n_err++; $display("FAIL mid_reset_async got %h want %h", obs_w, c_RST);
    end
    rom_fill(0);
    apply_reset();
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0, 0, 0);
      n_cmp++;
      if (obs_w !== exp_vec()) begin
        n_err++; $display("FAIL after_reset n=%0d got %h want %h", n, obs_w, exp_vec());
      end
      if (exp_out.h == 1 && exp_out.v == 0 && n < FRAME) begin
        n_cmp++;
        if (rom_addr !== AW'(2) || color_idx !== 3'd1) begin
          n_err++; $display("FAIL sprite_origin got addr %0d color %0d want 2 1", rom_addr, color_idx);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b1; pix_en = 1'b0; pos_valid = 1'b0; sprite_x = '0; sprite_y = '0;
    rom_fill(0);
    model_reset();
    test_reset();
    test_free_run();
    test_mid_update();
    test_clip();
    test_half_rate();
    test_reset_mid_sprite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
